// File: rtl/adder_apb_initiator_if.sv
// -----------------------------------------------------------------------------
// adder_apb_initiator_if
//
// Bundles the request, response and APB3 signals of the adder initiator.
//
//   Request  : i_req_valid, o_req_ready, i_req_a, i_req_b, i_req_op
//   Response : o_rsp_valid, i_rsp_ready, o_rsp_result, o_rsp_err
//   APB3     : PSEL, PENABLE, PWRITE, PADDR, PWDATA (from initiator)
//              PRDATA, PREADY, PSLVERR           (to initiator)
//
// Modports:
//   master - the initiator itself (drives the o_* and APB control signals)
//   slave  - the environment: request/response user plus APB peripheral
// -----------------------------------------------------------------------------
interface adder_apb_initiator_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    // Request channel
    logic              i_req_valid;
    logic              o_req_ready;
    logic [DATA_W-1:0] i_req_a;
    logic [DATA_W-1:0] i_req_b;
    logic              i_req_op;

    // Response channel
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_result;
    logic              o_rsp_err;

    // APB3
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  i_req_valid, i_req_a, i_req_b, i_req_op,
        output o_req_ready,
        output o_rsp_valid, o_rsp_result, o_rsp_err,
        input  i_rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output i_req_valid, i_req_a, i_req_b, i_req_op,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_result, o_rsp_err,
        output i_rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/adder_apb_initiator.sv
// -----------------------------------------------------------------------------
// adder_apb_initiator
//
// APB3 master that runs one add/sub operation on the adder peripheral:
// write A, write B, write CTRL {op, start}, poll STATUS until done, read
// RESULT, then present the result on the response channel.
//
// Parameters:
//   DATA_W    - operand/result/APB data width
//   ADDR_W    - APB address width
//   BASE_ADDR - peripheral base (A +0x00, B +0x04, CTRL +0x08,
//               STATUS +0x0C, RESULT +0x10)
//   POLL_MAX  - STATUS reads allowed per request before a timeout error
//
// Ports:
//   ACLK - clock, rising edge
//   ARST - asynchronous active-high reset
//   bus  - request/response/APB bundle (master modport)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module adder_apb_initiator #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int POLL_MAX  = 255
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    adder_apb_initiator_if.master bus
);

    // The counter only has to hold 0..POLL_MAX-1: the read that would take
    // it to POLL_MAX ends the request instead.
    localparam int POLL_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);

    localparam logic [ADDR_W-1:0] ADDR_A      = ADDR_W'(BASE_ADDR + 32'h00);
    localparam logic [ADDR_W-1:0] ADDR_B      = ADDR_W'(BASE_ADDR + 32'h04);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(BASE_ADDR + 32'h08);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(BASE_ADDR + 32'h0C);
    localparam logic [ADDR_W-1:0] ADDR_RESULT = ADDR_W'(BASE_ADDR + 32'h10);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_CTRL,
        POLL,
        RD_RES,
        RESP
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                op_q;
    logic [POLL_W-1:0]   poll_cnt;

    // Output registers
    logic                req_ready;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_err;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;

    assign bus.o_req_ready  = req_ready;
    assign bus.o_rsp_valid  = rsp_valid;
    assign bus.o_rsp_result = rsp_result;
    assign bus.o_rsp_err    = rsp_err;
    assign bus.PSEL         = psel;
    assign bus.PENABLE      = penable;
    assign bus.PWRITE       = pwrite;
    assign bus.PADDR        = paddr;
    assign bus.PWDATA       = pwdata;

    // -------------------------------------------------------------------------
    // Where the sequence goes when the transfer in ACCESS completes.
    // -------------------------------------------------------------------------
    logic   poll_last;
    state_t done_state;
    logic   done_err;

    assign poll_last = (poll_cnt == POLL_W'(POLL_MAX - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        done_state = state;
        done_err   = 1'b0;
        case (state)
            WR_A:    done_state = WR_B;
            WR_B:    done_state = WR_CTRL;
            WR_CTRL: done_state = POLL;
            POLL: begin
                if (bus.PRDATA[1]) begin
                    done_state = RD_RES;
                end else if (poll_last) begin
                    done_state = RESP;
                    done_err   = 1'b1;
                end else begin
                    done_state = POLL;
                end
            end
            RD_RES:  done_state = RESP;
            default: done_state = state;
        endcase
        // A slave error ends the request regardless of what the data said,
        // including on the last permitted poll.
        if (bus.PSLVERR) begin
            done_state = RESP;
            done_err   = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Address/direction/data for the next SETUP. The very first transfer is
    // issued from WR_A while the bus is idle; every later one is issued in the
    // same edge that completes its predecessor, so there is no idle cycle.
    // -------------------------------------------------------------------------
    state_t            issue_state;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_write;
    logic [DATA_W-1:0] issue_wdata;

    always_comb begin
        issue_state = psel ? done_state : state;
        issue_addr  = ADDR_A;
        issue_write = 1'b0;
        issue_wdata = '0;
        case (issue_state)
            WR_A: begin
                issue_addr  = ADDR_A;
                issue_write = 1'b1;
                issue_wdata = a_q;
            end
            WR_B: begin
                issue_addr  = ADDR_B;
                issue_write = 1'b1;
                issue_wdata = b_q;
            end
            WR_CTRL: begin
                // start=1 in bit0; the peripheral self-clears it.
                issue_addr  = ADDR_CTRL;
                issue_write = 1'b1;
                issue_wdata = DATA_W'({op_q, 1'b1});
            end
            POLL:    issue_addr = ADDR_STATUS;
            RD_RES:  issue_addr = ADDR_RESULT;
            default: issue_addr = ADDR_A;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer with registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: all state here is written with non-blocking assignments so every
    // register sees the values from before the edge, independent of order.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            poll_cnt   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        a_q       <= bus.i_req_a;
                        b_q       <= bus.i_req_b;
                        op_q      <= bus.i_req_op;
                        poll_cnt  <= '0;
                        req_ready <= 1'b0;
                        state     <= WR_A;
                    end
                end

                WR_A, WR_B, WR_CTRL, POLL, RD_RES: begin
                    if (!psel) begin
                        // SETUP of the first transfer of the request
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        paddr   <= issue_addr;
                        pwrite  <= issue_write;
                        pwdata  <= issue_wdata;
                    end else if (!penable) begin
                        penable <= 1'b1;
                    end else if (bus.PREADY) begin
                        state   <= done_state;
                        penable <= 1'b0;
                        if (state == POLL && done_state == POLL) begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                        if (done_state == RESP) begin
                            psel       <= 1'b0;
                            pwrite     <= 1'b0;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= done_err;
                            rsp_result <= (!done_err && state == RD_RES) ? bus.PRDATA : '0;
                        end else begin
                            // Back-to-back: PSEL stays high, next SETUP now
                            paddr  <= issue_addr;
                            pwrite <= issue_write;
                            pwdata <= issue_wdata;
                        end
                    end
                end

                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_adder_apb_initiator
//
// Directed bench for adder_apb_initiator. An APB slave model emulates the
// adder peripheral (configurable wait states, STATUS not-done count, slave
// error address/poll) and logs every completed transfer. Each request pushes
// its hand-computed response into a queue that a separate monitor pops and
// compares on every response handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_apb_initiator;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int POLL_MAX = 4;

    logic ACLK = 1'b0;
    logic ARST = 1'b1;
    always #5 ACLK = ~ACLK;

    adder_apb_initiator_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    adder_apb_initiator #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(0),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .ACLK(ACLK),
        .ARST(ARST),
        .bus (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              err;
    } rsp_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } xfer_t;

    rsp_t  exp_q[$];
    xfer_t log_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model configuration ----------------
    int          cfg_waits      = 0;  // wait states on each transfer (not-done polls excepted)
    int          cfg_notdone    = 0;  // STATUS reads returning done=0 before done=1
    bit          cfg_never_done = 0;
    bit          cfg_err_en     = 0;
    logic [7:0]  cfg_err_addr   = 8'h00;
    int          cfg_err_poll   = 0;  // PSLVERR on this STATUS read number (0 = off)
    int          poll_no        = 0;

    // ---------------- APB slave model ----------------
    initial begin : slave_model
        logic [31:0] reg_a, reg_b, rdata;
        logic        reg_op, perr, unstable, su_wr, is_poll, poll_done;
        logic [7:0]  su_addr;
        logic [31:0] su_wdata;
        int          waits_left;
        reg_a = '0; reg_b = '0; reg_op = 1'b0; waits_left = 0;
        unstable = 1'b0; su_wr = 1'b0; su_addr = '0; su_wdata = '0;
        is_poll = 1'b0; poll_done = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        forever begin
            @(negedge ACLK);
            if (ARST) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                waits_left  = 0;
            end else if (bus.PSEL && !bus.PENABLE) begin
                su_addr  = bus.PADDR;
                su_wdata = bus.PWDATA;
                su_wr    = bus.PWRITE;
                unstable = 1'b0;
                is_poll  = !bus.PWRITE && bus.PADDR == 8'h0C;
                if (is_poll) begin
                    poll_no++;
                    poll_done = !cfg_never_done && (poll_no > cfg_notdone);
                end
                // Not-done polls complete without wait states.
                waits_left  = (is_poll && !poll_done) ? 0 : cfg_waits;
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end else if (bus.PSEL && bus.PENABLE) begin
                if (bus.PADDR !== su_addr || bus.PWDATA !== su_wdata || bus.PWRITE !== su_wr)
                    unstable = 1'b1;
                if (waits_left > 0) begin
                    waits_left--;
                    bus.PREADY = 1'b0;
                end else begin
                    case (bus.PADDR)
                        8'h0C:   rdata = poll_done ? 32'h2 : 32'h1;
                        8'h10:   rdata = reg_op ? reg_a - reg_b : reg_a + reg_b;
                        default: rdata = 32'h0;
                    endcase
                    perr = (cfg_err_en && bus.PADDR == cfg_err_addr) ||
                           (is_poll && cfg_err_poll != 0 && poll_no == cfg_err_poll);
                    if (bus.PWRITE && !perr) begin
                        if (bus.PADDR == 8'h00) reg_a  = bus.PWDATA;
                        if (bus.PADDR == 8'h04) reg_b  = bus.PWDATA;
                        if (bus.PADDR == 8'h08) reg_op = bus.PWDATA[1];
                    end
                    bus.PRDATA  = rdata;
                    bus.PSLVERR = perr;
                    bus.PREADY  = 1'b1;
                    log_q.push_back('{bus.PWRITE, bus.PADDR, bus.PWRITE ? bus.PWDATA : rdata});
                    check("apb_stable", {63'd0, unstable}, 64'd0);
                end
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARST && bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 64'(bus.o_rsp_result), 64'(e.result));
                    check("rsp_err", 64'(bus.o_rsp_err), 64'(e.err));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_xfer(input string tag, input int idx, input logic wr,
                              input logic [7:0] addr, input logic [31:0] data);
        xfer_t x;
        x = '{wr, addr, data};
        if (idx < log_q.size())
            check($sformatf("%s_xfer%0d", tag, idx), 64'(log_q[idx]), 64'(x));
        else
            check($sformatf("%s_xfer%0d_missing", tag, idx), 64'd0, 64'd1);
    endtask

    // Issue one request (called #1 after a rising edge), wait for its
    // response, optionally backpressure it, then complete the handshake.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [31:0] exp_res, input logic exp_err,
                           input int exp_lat, input int hold);
        rsp_t e;
        int   n;
        logic bad;
        logic [33:0] held;
        e.result = exp_res;
        e.err    = exp_err;
        exp_q.push_back(e);
        log_q.delete();
        poll_no = 0;

        bus.i_req_a     = a;
        bus.i_req_b     = b;
        bus.i_req_op    = op;
        bus.i_req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!bus.o_req_ready && n < 50);
        check({tag, "_accept"}, 64'(bus.o_req_ready), 64'd1);
        @(posedge ACLK);  // accept edge
        #1 bus.i_req_valid = 1'b0;

        n = 0;
        while (!bus.o_rsp_valid && n < 400) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));

        if (hold > 0) begin
            held = {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_result};
            bad  = 1'b0;
            bus.i_req_valid = 1'b1;  // must be ignored while in RESP
            repeat (hold) begin
                @(negedge ACLK);
                if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_result} !== held || bus.o_req_ready !== 1'b0)
                    bad = 1'b1;
            end
            check({tag, "_hold_stable"}, {63'd0, bad}, 64'd0);
        end

        @(posedge ACLK);
        #1;
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        @(posedge ACLK);  // handshake edge
        #1 bus.i_rsp_ready = 1'b0;
        check({tag, "_ready_after"}, 64'(bus.o_req_ready), 64'd1);
        check({tag, "_valid_after"}, 64'(bus.o_rsp_valid), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int  n;
        logic bad;
        bus.i_req_valid = 1'b0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_req_op    = 1'b0;
        bus.i_rsp_ready = 1'b0;

        ARST = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_rsp_result", 64'(bus.o_rsp_result), 64'd0);
        check("rst_rsp_err", 64'(bus.o_rsp_err), 64'd0);
        check("rst_psel", 64'(bus.PSEL), 64'd0);
        check("rst_penable", 64'(bus.PENABLE), 64'd0);
        check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check("rst_paddr", 64'(bus.PADDR), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        ARST = 1'b0;
        @(posedge ACLK);
        #1;

        // Basic add 5+7
        run_req("add", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 11, 0);
        check("add_nxfer", 64'(log_q.size()), 64'd5);
        check_xfer("add", 0, 1'b1, 8'h00, 32'd5);
        check_xfer("add", 1, 1'b1, 8'h04, 32'd7);
        check_xfer("add", 2, 1'b1, 8'h08, 32'h1);
        check_xfer("add", 3, 1'b0, 8'h0C, 32'h2);
        check_xfer("add", 4, 1'b0, 8'h10, 32'd12);

        // Subtract: 20-3, CTRL = {op=1, start=1}
        run_req("sub", 32'd20, 32'd3, 1'b1, 32'd17, 1'b0, 11, 0);
        check_xfer("sub", 2, 1'b1, 8'h08, 32'h3);

        // Wrap-around add
        run_req("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0, 11, 0);

        // 2 wait states, 3 not-done polls: 11 + 10 + 6 = 27
        cfg_waits   = 2;
        cfg_notdone = 3;
        run_req("wait", 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 27, 0);
        check("wait_nxfer", 64'(log_q.size()), 64'd8);
        check_xfer("wait", 3, 1'b0, 8'h0C, 32'h1);
        check_xfer("wait", 5, 1'b0, 8'h0C, 32'h1);
        check_xfer("wait", 6, 1'b0, 8'h0C, 32'h2);
        check_xfer("wait", 7, 1'b0, 8'h10, 32'd123);
        cfg_waits   = 0;
        cfg_notdone = 0;

        // PSLVERR on the write to B: abort after 2 transfers
        cfg_err_en   = 1'b1;
        cfg_err_addr = 8'h04;
        run_req("slverr", 32'd9, 32'd9, 1'b0, 32'd0, 1'b1, 5, 0);
        check("slverr_nxfer", 64'(log_q.size()), 64'd2);
        cfg_err_en = 1'b0;

        // Timeout: done never set, exactly POLL_MAX STATUS reads
        cfg_never_done = 1'b1;
        run_req("timeout", 32'd1, 32'd2, 1'b0, 32'd0, 1'b1, 15, 0);
        check("timeout_nxfer", 64'(log_q.size()), 64'd7);
        check_xfer("timeout", 6, 1'b0, 8'h0C, 32'h1);

        // PSLVERR on the final permitted poll
        cfg_err_poll = 4;
        run_req("lastpoll", 32'd3, 32'd4, 1'b0, 32'd0, 1'b1, 15, 0);
        check("lastpoll_nxfer", 64'(log_q.size()), 64'd7);
        cfg_err_poll   = 0;
        cfg_never_done = 1'b0;

        // Response backpressure for 5 cycles, then a fresh request
        run_req("bp", 32'd40, 32'd2, 1'b1, 32'd38, 1'b0, 11, 5);
        run_req("after_bp", 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 11, 0);

        // Reset during ACCESS of the CTRL write
        cfg_waits = 3;
        log_q.delete();
        poll_no = 0;
        bus.i_req_a     = 32'd1;
        bus.i_req_b     = 32'd2;
        bus.i_req_op    = 1'b0;
        bus.i_req_valid = 1'b1;
        @(posedge ACLK);
        #1 bus.i_req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(bus.PSEL && bus.PENABLE && bus.PADDR == 8'h08) && n < 60);
        check("rstmid_ctrl_access", 64'(bus.PSEL && bus.PENABLE && bus.PADDR == 8'h08), 64'd1);
        #2 ARST = 1'b1;
        #1;
        check("rstmid_psel", 64'(bus.PSEL), 64'd0);
        check("rstmid_penable", 64'(bus.PENABLE), 64'd0);
        check("rstmid_req_ready", 64'(bus.o_req_ready), 64'd1);
        check("rstmid_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        @(posedge ACLK);
        #1 ARST = 1'b0;
        cfg_waits = 0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge ACLK);
            if (bus.o_rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) bad = 1'b1;
        end
        check("rstmid_no_rsp", {63'd0, bad}, 64'd0);
        @(posedge ACLK);
        #1;
        run_req("post_rst", 32'd6, 32'd6, 1'b0, 32'd12, 1'b0, 11, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
